ordenador_escritas_rr: RTL and testbench
========================================

Name: ordenador_escritas_rr

Overview:
- Parametrised successor to the write-ordering stage between the NUM_EA approved-node expanders and the active-node evaluator.
- Arbitrates update commands with a fair round-robin arbiter.
- Buffers accepted commands in a FIFO_DEPTH-deep queue.
- Drives the evaluator through a held valid/ready handshake that carries the originating channel index.
- Sustains one accepted command per cycle when two or more expanders request, instead of one command per full evaluator round-trip.

Parameters:
- ADDR_WIDTH, 10, node address width.
- DISTANCIA_WIDTH, 6, distance field width.
- CUSTO_WIDTH, 4, cost field width.
- NUM_READ_PORTS, 8, neighbours per command.
- NUM_EA, 8, number of expander channels; must be ≥ 2.
- FIFO_DEPTH, 4, command queue depth; power of 2, ≥ 2.
- Derived: EA_IDX_W = clog2(NUM_EA); CNT_W = clog2(FIFO_DEPTH)+1; PAYLOAD_W = NUM_READ_PORTS*(1+ADDR_WIDTH+CUSTO_WIDTH+DISTANCIA_WIDTH)+ADDR_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ea_atualizar_in  in  NUM_EA  per-channel request.
- ea_atualizar_ready_out  out  NUM_EA  one-cycle accept pulse per channel.
- ea_vizinho_valido_in  in  NUM_READ_PORTS*NUM_EA  neighbour-valid flags, channel-major.
- ea_endereco_in  in  ADDR_WIDTH*NUM_READ_PORTS*NUM_EA  neighbour addresses.
- ea_menor_vizinho_in  in  CUSTO_WIDTH*NUM_READ_PORTS*NUM_EA  neighbour costs.
- ea_distancia_in  in  DISTANCIA_WIDTH*NUM_READ_PORTS*NUM_EA  neighbour distances.
- ea_anterior_in  in  ADDR_WIDTH*NUM_EA  parent node per channel.
- aa_atualizar_ready_in  in  1  evaluator accepts the presented command.
- aa_ocupado_in  in  1  evaluator busy; blocks loading of a new output command.
- oe_atualizar_out  out  1  output valid.
- oe_vizinho_valido_out  out  NUM_READ_PORTS  selected valid flags.
- oe_endereco_out  out  ADDR_WIDTH*NUM_READ_PORTS  selected addresses.
- oe_menor_vizinho_out  out  CUSTO_WIDTH*NUM_READ_PORTS  selected costs.
- oe_distancia_out  out  DISTANCIA_WIDTH*NUM_READ_PORTS  selected distances.
- oe_anterior_out  out  ADDR_WIDTH  selected parent.
- oe_origem_out  out  EA_IDX_W  channel index of the presented command.

Behaviour:
- Reset (async, rst_n low): all outputs 0, FIFO empty, round-robin pointer 0, mask 0. Requests still pending when reset releases are re-arbitrated from scratch.
- Expander contract: holds its request and payload stable until it sees its ready pulse; deasserts at or after the next edge.
- Arbitration, per cycle t:
  - eligible = ea_atualizar_in & ~mask.
  - Grant only if eligible≠0 and registered count < FIFO_DEPTH. A simultaneous pop is not credited, so a full FIFO never grants.
  - Winner is the first eligible index searching upward from rr_ptr, wrapping at NUM_EA.
  - On grant, the winner's {index, payload} is written to the FIFO at edge t+1 and rr_ptr becomes winner+1 (mod NUM_EA).
  - ea_atualizar_ready_out[winner]=1 during cycle t+1 only; at most one bit set per cycle.
  - mask = one-hot(winner) during cycle t+1, which blocks re-grant of the still-high request; otherwise mask=0.
- Output stage: a registered slice ahead of the ports.
  - Loads the FIFO head when (slice empty OR aa_atualizar_ready_in&oe_atualizar_out) AND FIFO non-empty AND !aa_ocupado_in.
  - Once oe_atualizar_out=1, the slice contents and valid stay stable until aa_atualizar_ready_in; aa_ocupado_in never drops a presented valid.
  - Transfer happens on valid&ready. A new head can load in the same cycle as the transfer, giving back-to-back throughput of 1 per cycle.
  - When ready arrives with the FIFO empty, or with aa_ocupado_in high, the slice is cleared (oe_atualizar_out←0, data held).
- Latency: request at cycle t → FIFO write t+1 → oe_atualizar_out at t+2 when the path is idle.
- Count: +1 on write, -1 on load into the slice, unchanged when both occur; it never underflows or overflows.
- Ordering: commands leave in acceptance order; no reordering.

Optional Feature:
- Macro: ORDENADOR_ESCRITAS_STATS_EN.
- Defined: adds outputs oe_stat_aceitos_out[31:0] (commands accepted, saturating), oe_stat_ocupacao_max_out[CNT_W-1:0] (FIFO high-water mark), and oe_stat_bloqueios_out[31:0] (cycles with requests pending while the FIFO is full, saturating). All three reset to 0.
- Not defined: these ports and their counters do not exist; core behaviour is identical either way.

Decomposition:
- Shared include ordenador_defs.vh holds the PAYLOAD_W/EA_IDX_W/CNT_W localparam formulas and a clog2 function, reused by the evaluator.
- Sub-module fifo_sincrona (params WIDTH, DEPTH; ports clk, rst_n, push, pop, din, dout, count, full, empty) instantiated with WIDTH = EA_IDX_W+PAYLOAD_W.
- The arbiter and output slice stay in the top level.

Test Plan:
- NUM_EA=4, FIFO_DEPTH=4, AA always ready, only ch2 requests with anterior=0x05A:
  - ready_out=4'b0100 in cycle 1.
  - oe_atualizar_out=1 with oe_anterior_out=0x05A and oe_origem_out=2 in cycle 2.
  - No second grant of ch2 while it is masked.
- All 4 channels request continuously: grant order 0,1,2,3,0,… with one ready pulse per cycle; outputs carry origem 0,1,2,3 in order.
- aa_atualizar_ready_in=0 with all channels requesting:
  - FIFO fills to 4 and the slice holds 1.
  - No ready pulses afterwards (exactly 5 accepted).
  - One ready cycle → exactly one new grant two cycles later.
- aa_ocupado_in=1 while the FIFO is non-empty and the slice is empty: oe_atualizar_out stays 0; deassert → valid rises the next cycle with the head command.
- rst_n pulsed low mid-stream with 3 queued: all outputs 0 immediately; after release, rr_ptr=0 and the held requests are re-granted starting at the lowest requesting index.
- With ORDENADOR_ESCRITAS_STATS_EN: after the stall scenario, aceitos=5, ocupacao_max=4, bloqueios equals the counted stall cycles.

Source files
------------

// File: rtl/ordenador_escritas_rr_pkg.sv
// Shared definitions for the write-ordering stage: width helpers reused by
// the ordering stage, its FIFO and the active-node evaluator.
package ordenador_escritas_rr_pkg;

   // Ceiling log2, with a minimum of 1 bit so single-entry indices stay legal
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

   // One command: per neighbour {valid, address, cost, distance} plus the parent
   function automatic int payload_w(input int addr_w, input int custo_w,
                                    input int dist_w, input int num_ports);
      return num_ports * (1 + addr_w + custo_w + dist_w) + addr_w;
   endfunction

   // Occupancy counter must reach DEPTH itself, hence the extra bit
   function automatic int cnt_w(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ordenador_escritas_rr_fifo.sv
// Synchronous FIFO for accepted update commands. Combinational head read,
// DEPTH must be a power of two so pointers wrap naturally.
module fifo_sincrona
   import ordenador_escritas_rr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [clog2(DEPTH):0]  count,
   output logic                   full,
   output logic                   empty
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/ordenador_escritas_rr.sv
// Write-ordering stage: round-robin arbitration over NUM_EA expanders, a
// command FIFO and a registered valid/ready slice towards the evaluator.
// Optional statistics outputs are enabled with ORDENADOR_ESCRITAS_STATS_EN.
module ordenador_escritas_rr
   import ordenador_escritas_rr_pkg::*;
#(
   parameter  int ADDR_WIDTH      = 10,
   parameter  int DISTANCIA_WIDTH = 6,
   parameter  int CUSTO_WIDTH     = 4,
   parameter  int NUM_READ_PORTS  = 8,
   parameter  int NUM_EA          = 8,
   parameter  int FIFO_DEPTH      = 4,
   localparam int EA_IDX_W        = clog2(NUM_EA),
   localparam int CNT_W           = cnt_w(FIFO_DEPTH),
   localparam int PAYLOAD_W       = payload_w(ADDR_WIDTH, CUSTO_WIDTH, DISTANCIA_WIDTH, NUM_READ_PORTS)
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic [NUM_EA-1:0]                           ea_atualizar_in,
   output logic [NUM_EA-1:0]                           ea_atualizar_ready_out,
   input  logic [NUM_READ_PORTS*NUM_EA-1:0]            ea_vizinho_valido_in,
   input  logic [ADDR_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] ea_endereco_in,
   input  logic [CUSTO_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] ea_menor_vizinho_in,
   input  logic [DISTANCIA_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] ea_distancia_in,
   input  logic [ADDR_WIDTH*NUM_EA-1:0]                ea_anterior_in,
   input  logic                                        aa_atualizar_ready_in,
   input  logic                                        aa_ocupado_in,
   output logic                                        oe_atualizar_out,
   output logic [NUM_READ_PORTS-1:0]                   oe_vizinho_valido_out,
   output logic [ADDR_WIDTH*NUM_READ_PORTS-1:0]        oe_endereco_out,
   output logic [CUSTO_WIDTH*NUM_READ_PORTS-1:0]       oe_menor_vizinho_out,
   output logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0]   oe_distancia_out,
   output logic [ADDR_WIDTH-1:0]                       oe_anterior_out,
`ifdef ORDENADOR_ESCRITAS_STATS_EN
   output logic [31:0]                                 oe_stat_aceitos_out,
   output logic [CNT_W-1:0]                            oe_stat_ocupacao_max_out,
   output logic [31:0]                                 oe_stat_bloqueios_out,
`endif
   output logic [EA_IDX_W-1:0]                         oe_origem_out
);

   localparam int VV_W    = NUM_READ_PORTS;
   localparam int AD_W    = ADDR_WIDTH * NUM_READ_PORTS;
   localparam int CU_W    = CUSTO_WIDTH * NUM_READ_PORTS;
   localparam int DI_W    = DISTANCIA_WIDTH * NUM_READ_PORTS;
   localparam int ENTRY_W = EA_IDX_W + PAYLOAD_W;

   logic [NUM_EA-1:0]    mask;
   logic [NUM_EA-1:0]    eligible;
   logic [NUM_EA-1:0]    grant_onehot;
   logic [EA_IDX_W-1:0]  rr_ptr;
   logic [EA_IDX_W-1:0]  winner;
   logic                 grant;
   int                   best_dist;
   int                   cand_dist;
   logic [PAYLOAD_W-1:0] win_payload;
   logic [ENTRY_W-1:0]   fifo_din;
   logic [ENTRY_W-1:0]   fifo_dout;
   logic [CNT_W-1:0]     fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 slice_load;
   logic                 slice_xfer;

   // The mask register doubles as the accept pulse: both are one-hot(winner)
   // for the single cycle after a grant
   assign ea_atualizar_ready_out = mask;

   // Round-robin search: the eligible channel closest above rr_ptr wins.
   // Grants depend only on registered occupancy, so a pop in the same cycle
   // never opens room in a full queue.
   always_comb begin
      eligible     = ea_atualizar_in & ~mask;
      winner       = '0;
      best_dist    = NUM_EA;
      cand_dist    = 0;
      for (int c = 0; c < NUM_EA; c++) begin
         cand_dist = c - int'(rr_ptr);
         if (cand_dist < 0) begin
            cand_dist = cand_dist + NUM_EA;
         end
         if (eligible[c] && (cand_dist < best_dist)) begin
            best_dist = cand_dist;
            winner    = EA_IDX_W'(c);
         end
      end
      grant        = (|eligible) && !fifo_full && (fifo_count < CNT_W'(FIFO_DEPTH));
      grant_onehot = {{(NUM_EA-1){1'b0}}, 1'b1} << winner;
   end

   // Gather the winning channel's command into one packed FIFO entry
   always_comb begin
      win_payload = '0;
      for (int c = 0; c < NUM_EA; c++) begin
         if (winner == EA_IDX_W'(c)) begin
            win_payload = {ea_vizinho_valido_in[c*VV_W +: VV_W],
                           ea_endereco_in[c*AD_W +: AD_W],
                           ea_menor_vizinho_in[c*CU_W +: CU_W],
                           ea_distancia_in[c*DI_W +: DI_W],
                           ea_anterior_in[c*ADDR_WIDTH +: ADDR_WIDTH]};
         end
      end
   end

   assign fifo_din = {winner, win_payload};

   // Arbiter state: pointer advances past the winner, mask blocks the
   // still-high request of the channel that was just accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
         mask   <= '0;
      end else if (grant) begin
         mask   <= grant_onehot;
         rr_ptr <= (winner == EA_IDX_W'(NUM_EA-1)) ? '0 : winner + 1'b1;
      end else begin
         mask   <= '0;
      end
   end

   fifo_sincrona #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (grant),
      .pop   (slice_load),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign slice_xfer = oe_atualizar_out & aa_atualizar_ready_in;
   assign slice_load = (!oe_atualizar_out || slice_xfer) && !fifo_empty && !aa_ocupado_in;

   // Output slice: refills on the transfer cycle for back-to-back flow,
   // otherwise holds a presented command until the evaluator takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oe_atualizar_out      <= 1'b0;
         oe_origem_out         <= '0;
         oe_vizinho_valido_out <= '0;
         oe_endereco_out       <= '0;
         oe_menor_vizinho_out  <= '0;
         oe_distancia_out      <= '0;
         oe_anterior_out       <= '0;
      end else if (slice_load) begin
         oe_atualizar_out <= 1'b1;
         {oe_origem_out, oe_vizinho_valido_out, oe_endereco_out, oe_menor_vizinho_out,
          oe_distancia_out, oe_anterior_out} <= fifo_dout;
      end else if (slice_xfer) begin
         oe_atualizar_out <= 1'b0;
      end
   end

`ifdef ORDENADOR_ESCRITAS_STATS_EN
   // Saturating accept/block counters and the queue high-water mark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oe_stat_aceitos_out      <= '0;
         oe_stat_ocupacao_max_out <= '0;
         oe_stat_bloqueios_out    <= '0;
      end else begin
         if (grant && (oe_stat_aceitos_out != 32'hFFFF_FFFF)) begin
            oe_stat_aceitos_out <= oe_stat_aceitos_out + 32'd1;
         end
         if (fifo_count > oe_stat_ocupacao_max_out) begin
            oe_stat_ocupacao_max_out <= fifo_count;
         end
         if ((|ea_atualizar_in) && fifo_full && (oe_stat_bloqueios_out != 32'hFFFF_FFFF)) begin
            oe_stat_bloqueios_out <= oe_stat_bloqueios_out + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ordenador_escritas_rr.sv
// Directed bench for ordenador_escritas_rr with four expander channels.
// Inputs change 1 time unit after each rising edge; outputs are read on the
// falling edge of the same cycle.
module tb_ordenador_escritas_rr;

   localparam int ADDR_WIDTH      = 10;
   localparam int DISTANCIA_WIDTH = 6;
   localparam int CUSTO_WIDTH     = 4;
   localparam int NUM_READ_PORTS  = 8;
   localparam int NUM_EA          = 4;
   localparam int FIFO_DEPTH      = 4;
   localparam int EA_IDX_W        = 2;
   localparam int CNT_W           = 3;

   localparam logic [3:0] STALL_READY [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};

   logic clk;
   logic rst_n;
   logic [NUM_EA-1:0] ea_req;
   logic [NUM_EA-1:0] ea_ready;
   logic [NUM_READ_PORTS*NUM_EA-1:0] ea_vv;
   logic [ADDR_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] ea_end;
   logic [CUSTO_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] ea_custo;
   logic [DISTANCIA_WIDTH*NUM_READ_PORTS*NUM_EA-1:0] ea_dist;
   logic [ADDR_WIDTH*NUM_EA-1:0] ea_ant;
   logic aa_ready;
   logic aa_ocupado;
   logic oe_valid;
   logic [NUM_READ_PORTS-1:0] oe_vv;
   logic [ADDR_WIDTH*NUM_READ_PORTS-1:0] oe_end;
   logic [CUSTO_WIDTH*NUM_READ_PORTS-1:0] oe_custo;
   logic [DISTANCIA_WIDTH*NUM_READ_PORTS-1:0] oe_dist;
   logic [ADDR_WIDTH-1:0] oe_ant;
   logic [EA_IDX_W-1:0] oe_origem;
`ifdef ORDENADOR_ESCRITAS_STATS_EN
   logic [31:0] stat_aceitos;
   logic [CNT_W-1:0] stat_max;
   logic [31:0] stat_bloq;
`endif

   int check_count;
   int fail_count;

   ordenador_escritas_rr #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .DISTANCIA_WIDTH (DISTANCIA_WIDTH),
      .CUSTO_WIDTH     (CUSTO_WIDTH),
      .NUM_READ_PORTS  (NUM_READ_PORTS),
      .NUM_EA          (NUM_EA),
      .FIFO_DEPTH      (FIFO_DEPTH)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .ea_atualizar_in        (ea_req),
      .ea_atualizar_ready_out (ea_ready),
      .ea_vizinho_valido_in   (ea_vv),
      .ea_endereco_in         (ea_end),
      .ea_menor_vizinho_in    (ea_custo),
      .ea_distancia_in        (ea_dist),
      .ea_anterior_in         (ea_ant),
      .aa_atualizar_ready_in  (aa_ready),
      .aa_ocupado_in          (aa_ocupado),
      .oe_atualizar_out       (oe_valid),
      .oe_vizinho_valido_out  (oe_vv),
      .oe_endereco_out        (oe_end),
      .oe_menor_vizinho_out   (oe_custo),
      .oe_distancia_out       (oe_dist),
      .oe_anterior_out        (oe_ant),
`ifdef ORDENADOR_ESCRITAS_STATS_EN
      .oe_stat_aceitos_out      (stat_aceitos),
      .oe_stat_ocupacao_max_out (stat_max),
      .oe_stat_bloqueios_out    (stat_bloq),
`endif
      .oe_origem_out          (oe_origem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it when observed and expected differ
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      check_count = check_count + 1;
      if (observed !== expected) begin
         fail_count = fail_count + 1;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Move to the next cycle, drive inputs, then wait for the sampling point
   task automatic applyStimulus(input logic [NUM_EA-1:0] req, input logic rdy, input logic ocup);
      @(posedge clk);
      #1;
      ea_req     = req;
      aa_ready   = rdy;
      aa_ocupado = ocup;
      @(negedge clk);
   endtask

   // Hold reset for one full cycle, releasing it just after a rising edge
   task automatic resetDut();
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      ea_req     = '0;
      aa_ready   = 1'b1;
      aa_ocupado = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      check_count = 0;
      fail_count  = 0;
      rst_n       = 1'b0;
      ea_req      = '0;
      aa_ready    = 1'b1;
      aa_ocupado  = 1'b0;
      for (int c = 0; c < NUM_EA; c++) begin
         ea_ant[c*ADDR_WIDTH +: ADDR_WIDTH] = 10'h058 + 10'(c);
         ea_vv[c*NUM_READ_PORTS +: NUM_READ_PORTS] = 8'hA0 | 8'(c);
         for (int n = 0; n < NUM_READ_PORTS; n++) begin
            ea_end[(c*NUM_READ_PORTS+n)*ADDR_WIDTH +: ADDR_WIDTH]               = 10'(c*16 + n);
            ea_custo[(c*NUM_READ_PORTS+n)*CUSTO_WIDTH +: CUSTO_WIDTH]           = 4'(c + n);
            ea_dist[(c*NUM_READ_PORTS+n)*DISTANCIA_WIDTH +: DISTANCIA_WIDTH]    = 6'(c*8 + n);
         end
      end

      // Reset state
      #2;
      checkOutput("rst_valid", 64'(oe_valid), 64'd0);
      checkOutput("rst_ready", 64'(ea_ready), 64'd0);
      checkOutput("rst_origem", 64'(oe_origem), 64'd0);
      checkOutput("rst_anterior", 64'(oe_ant), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single requester on channel 2
      applyStimulus(4'b0100, 1'b1, 1'b0);
      checkOutput("single_c0_ready", 64'(ea_ready), 64'd0);
      checkOutput("single_c0_valid", 64'(oe_valid), 64'd0);
      applyStimulus(4'b0100, 1'b1, 1'b0);
      checkOutput("single_c1_ready", 64'(ea_ready), 64'h4);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("single_c2_valid", 64'(oe_valid), 64'd1);
      checkOutput("single_c2_anterior", 64'(oe_ant), 64'h05A);
      checkOutput("single_c2_origem", 64'(oe_origem), 64'd2);
      checkOutput("single_c2_vv", 64'(oe_vv), 64'hA2);
      checkOutput("single_c2_end3", 64'(oe_end[3*ADDR_WIDTH +: ADDR_WIDTH]), 64'h023);
      checkOutput("single_c2_custo5", 64'(oe_custo[5*CUSTO_WIDTH +: CUSTO_WIDTH]), 64'd7);
      checkOutput("single_c2_dist5", 64'(oe_dist[5*DISTANCIA_WIDTH +: DISTANCIA_WIDTH]), 64'd21);
      checkOutput("single_c2_no_regrant", 64'(ea_ready), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("single_c3_valid", 64'(oe_valid), 64'd0);
      checkOutput("single_c3_ready", 64'(ea_ready), 64'd0);

      // All channels requesting, evaluator always ready
      resetDut();
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput("rr_c0_ready", 64'(ea_ready), 64'd0);
      for (int k = 0; k < 6; k++) begin
         logic [3:0] exp_ready;
         exp_ready = 4'b0001 << (k % 4);
         applyStimulus(4'b1111, 1'b1, 1'b0);
         checkOutput($sformatf("rr_ready_%0d", k), 64'(ea_ready), 64'(exp_ready));
         if (k >= 1) begin
            checkOutput($sformatf("rr_valid_%0d", k), 64'(oe_valid), 64'd1);
            checkOutput($sformatf("rr_origem_%0d", k), 64'(oe_origem), 64'((k - 1) % 4));
            checkOutput($sformatf("rr_anterior_%0d", k), 64'(oe_ant), 64'(10'h058 + 10'((k - 1) % 4)));
         end
      end

      // Evaluator stalled: five accepts fill slice plus queue, then nothing
      resetDut();
      applyStimulus(4'b1111, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         applyStimulus(4'b1111, 1'b0, 1'b0);
         checkOutput($sformatf("stall_ready_%0d", k), 64'(ea_ready), 64'(STALL_READY[k]));
         if (k >= 1) begin
            checkOutput($sformatf("stall_origem_%0d", k), 64'(oe_origem), 64'd0);
            checkOutput($sformatf("stall_valid_%0d", k), 64'(oe_valid), 64'd1);
         end
      end
`ifdef ORDENADOR_ESCRITAS_STATS_EN
      checkOutput("stat_aceitos", 64'(stat_aceitos), 64'd5);
      checkOutput("stat_ocupacao_max", 64'(stat_max), 64'd4);
      checkOutput("stat_bloqueios", 64'(stat_bloq), 64'd4);
`endif
      applyStimulus(4'b1111, 1'b1, 1'b0);
      checkOutput("stall_drain_ready", 64'(ea_ready), 64'd0);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("stall_next_ready", 64'(ea_ready), 64'd0);
      checkOutput("stall_next_origem", 64'(oe_origem), 64'd1);
      checkOutput("stall_next_valid", 64'(oe_valid), 64'd1);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("stall_regrant", 64'(ea_ready), 64'h2);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("stall_after_a", 64'(ea_ready), 64'd0);
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("stall_after_b", 64'(ea_ready), 64'd0);

      // Evaluator busy while a command waits in the queue
      resetDut();
      applyStimulus(4'b0010, 1'b1, 1'b1);
      checkOutput("busy_e0_valid", 64'(oe_valid), 64'd0);
      applyStimulus(4'b0010, 1'b1, 1'b1);
      checkOutput("busy_e1_ready", 64'(ea_ready), 64'h2);
      checkOutput("busy_e1_valid", 64'(oe_valid), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("busy_e2_valid", 64'(oe_valid), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("busy_e3_valid", 64'(oe_valid), 64'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0);
      checkOutput("busy_e4_valid", 64'(oe_valid), 64'd0);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("busy_e5_valid", 64'(oe_valid), 64'd1);
      checkOutput("busy_e5_origem", 64'(oe_origem), 64'd1);
      checkOutput("busy_e5_anterior", 64'(oe_ant), 64'h059);
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkOutput("busy_e6_hold", 64'(oe_valid), 64'd1);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("busy_e7_hold", 64'(oe_valid), 64'd1);
      applyStimulus(4'b0000, 1'b0, 1'b0);
      checkOutput("busy_e8_clear", 64'(oe_valid), 64'd0);

      // Reset pulsed with three commands queued
      resetDut();
      applyStimulus(4'b0111, 1'b0, 1'b0);
      applyStimulus(4'b0111, 1'b0, 1'b0);
      applyStimulus(4'b0111, 1'b0, 1'b0);
      applyStimulus(4'b0111, 1'b0, 1'b0);
      checkOutput("mid_f3_ready", 64'(ea_ready), 64'h4);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_valid", 64'(oe_valid), 64'd0);
      checkOutput("mid_rst_ready", 64'(ea_ready), 64'd0);
      checkOutput("mid_rst_origem", 64'(oe_origem), 64'd0);
      checkOutput("mid_rst_anterior", 64'(oe_ant), 64'd0);
      checkOutput("mid_rst_vv", 64'(oe_vv), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("mid_rel_ready", 64'(ea_ready), 64'd0);
      checkOutput("mid_rel_valid", 64'(oe_valid), 64'd0);
      applyStimulus(4'b0111, 1'b0, 1'b0);
      checkOutput("mid_g0_ready", 64'(ea_ready), 64'h1);
      applyStimulus(4'b0111, 1'b0, 1'b0);
      checkOutput("mid_g1_ready", 64'(ea_ready), 64'h2);
      checkOutput("mid_g1_valid", 64'(oe_valid), 64'd1);
      checkOutput("mid_g1_origem", 64'(oe_origem), 64'd0);
      applyStimulus(4'b0111, 1'b0, 1'b0);
      checkOutput("mid_g2_ready", 64'(ea_ready), 64'h4);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
